qpu_exu_alu_dpath_arb: RTL and testbench
========================================

// Module: qpu_exu_alu_dpath_arb
// PURPOSE
//  Requestor-side arbiter/issuer for the shared EXU ALU datapath. Collects valid/ready requests
//  from the ALU, BJP, LSU and QIU units, grants at most one per cycle, and drives that unit's
//  one-hot request select into the datapath. Captures the datapath result into a one-entry
//  response register returned over a valid/ready channel tagged with the requestor id.
//  Operand/opcode buses run directly from each unit to the datapath; only the selects pass here.
// PARAMETERS
//  XLEN   `QPU_XLEN (32)  datapath result width
//  RR_EN  1               1: round-robin grant; 0: fixed priority ALU>BJP>LSU>QIU
// PORTS
//  clk            in   1     core clock
//  rst_n          in   1     asynchronous, active-low reset
//  flush          in   1     synchronous pipeline flush
//  alu_i_valid    in   1     ALU unit request valid
//  alu_i_ready    out  1     ALU request accepted this cycle
//  bjp_i_valid    in   1     BJP unit compare-request valid
//  bjp_i_ready    out  1     BJP request accepted this cycle
//  lsu_i_valid    in   1     LSU unit address-add request valid
//  lsu_i_ready    out  1     LSU request accepted this cycle
//  qiu_i_valid    in   1     QIU unit add request valid
//  qiu_i_ready    out  1     QIU request accepted this cycle
//  alu_req_alu    out  1     datapath select: ALU owns datapath this cycle
//  bjp_req_alu    out  1     datapath select: BJP
//  lsu_req_alu    out  1     datapath select: LSU
//  qiu_req_alu    out  1     datapath select: QIU
//  dpath_res      in   XLEN  datapath arithmetic/logic result (same cycle as select)
//  dpath_cmp_res  in   1     datapath compare result (same cycle as select)
//  o_valid        out  1     response valid
//  o_ready        in   1     response consumer ready
//  o_res          out  XLEN  registered result
//  o_cmp          out  1     registered compare result (meaningful for id 1 only)
//  o_id           out  2     requestor id: 0 ALU, 1 BJP, 2 LSU, 3 QIU
// BEHAVIOUR
//  - Reset (rst_n=0, async): o_valid=0, o_res=0, o_cmp=0, o_id=0, rr pointer=0 (ALU first).
//    All *_i_ready and *_req_alu are combinational and 0 while o_valid=0 and no valid input.
//  - can_issue = (~o_valid | o_ready) & ~flush.
//  - Grant: combinational over {alu,bjp,lsu,qiu}_i_valid. RR_EN=1: first valid at or after
//    pointer, wrapping 3->0. RR_EN=0: fixed priority. Grant gated by can_issue.
//  - Granted unit: its *_req_alu=1 and *_i_ready=1 in the same cycle; all others 0.
//    *_req_alu is one-hot or zero in every cycle (never two selects high).
//  - Accept (granted valid&ready): on next clk o_valid=1, o_res<=dpath_res, o_cmp<=dpath_cmp_res
//    (forced 0 unless BJP), o_id<=grant id. RR pointer <= (grant id + 1) mod 4.
//  - Latency: request accept to o_valid = 1 cycle. Throughput 1/cycle when o_ready held 1.
//  - Response: o_valid/o_res/o_cmp/o_id hold stable while o_valid & ~o_ready.
//    o_valid&o_ready with no new accept -> o_valid=0 next cycle, data regs hold.
//    Drain and new accept in same cycle -> o_valid stays 1 with new data (no bubble).
//  - Backpressure: o_valid & ~o_ready -> no grant, all *_i_ready=0; pointer frozen.
//  - Requestors must hold valid (and operands) stable until ready; arbiter does not check.
//  - flush=1: no grant that cycle; o_valid<=0 next cycle, pointer unchanged. flush wins over
//    any simultaneous o_ready drain or accept.
//  - Reset asserted mid-operation: pending response discarded, all state to reset values.
// TESTING
//  1 Single LSU request, o_ready=1, dpath_res=0x0000_1004 -> lsu_req_alu=1 same cycle;
//    next cycle o_valid=1, o_res=0x0000_1004, o_id=2, o_cmp=0.
//  2 All four valid continuously, o_ready=1, RR_EN=1 -> grant ids 0,1,2,3,0 on consecutive
//    cycles; selects always one-hot.
//  3 BJP eq request, dpath_cmp_res=1, o_ready=0 for 3 cycles -> o_valid=1,o_id=1,o_cmp=1 held
//    stable 3 cycles, bjp/alu i_ready=0 throughout; accept resumes cycle o_ready rises.
//  4 RR_EN=0, ALU and QIU valid 5 cycles -> ALU granted all 5 cycles, qiu_i_ready=0.
//  5 o_valid=1 with ALU valid, flush=1 -> no select asserted, o_valid=0 next cycle, pointer same.
//  6 rst_n low mid-stall with o_valid=1 -> o_valid=0,o_res=0 immediately (async), ALU first after.

Source files
------------

// File: rtl/qpu_exu_alu_dpath_arb_if.sv
// Request/select/response bundle between the EXU units, the shared ALU datapath and
// the result consumer. The slave modport is the arbiter's view; master is the environment's.
`ifndef QPU_XLEN
`define QPU_XLEN 32
`endif

interface qpu_exu_alu_dpath_arb_if #(
  parameter int XLEN = `QPU_XLEN
);
  logic            flush;
  logic            alu_i_valid;
  logic            alu_i_ready;
  logic            bjp_i_valid;
  logic            bjp_i_ready;
  logic            lsu_i_valid;
  logic            lsu_i_ready;
  logic            qiu_i_valid;
  logic            qiu_i_ready;
  logic            alu_req_alu;
  logic            bjp_req_alu;
  logic            lsu_req_alu;
  logic            qiu_req_alu;
  logic [XLEN-1:0] dpath_res;
  logic            dpath_cmp_res;
  logic            o_valid;
  logic            o_ready;
  logic [XLEN-1:0] o_res;
  logic            o_cmp;
  logic [1:0]      o_id;

  modport slave (
    input  flush,
    input  alu_i_valid, bjp_i_valid, lsu_i_valid, qiu_i_valid,
    output alu_i_ready, bjp_i_ready, lsu_i_ready, qiu_i_ready,
    output alu_req_alu, bjp_req_alu, lsu_req_alu, qiu_req_alu,
    input  dpath_res, dpath_cmp_res,
    output o_valid, o_res, o_cmp, o_id,
    input  o_ready
  );

  modport master (
    output flush,
    output alu_i_valid, bjp_i_valid, lsu_i_valid, qiu_i_valid,
    input  alu_i_ready, bjp_i_ready, lsu_i_ready, qiu_i_ready,
    input  alu_req_alu, bjp_req_alu, lsu_req_alu, qiu_req_alu,
    output dpath_res, dpath_cmp_res,
    input  o_valid, o_res, o_cmp, o_id,
    output o_ready
  );
endinterface

// File: rtl/qpu_exu_alu_dpath_arb.sv
// Arbiter for the shared EXU ALU datapath: grants one of ALU/BJP/LSU/QIU per cycle,
// drives its datapath select, and registers the result into a one-entry response slot.
module qpu_exu_alu_dpath_arb #(
  parameter int XLEN  = `QPU_XLEN,
  parameter bit RR_EN = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  qpu_exu_alu_dpath_arb_if.slave       bus
);

  localparam logic [1:0] ID_BJP = 2'd1;

  logic [3:0]      vld_vec;
  logic [3:0]      gnt_oh;
  logic [1:0]      gnt_id;
  logic            gnt_found;
  logic            can_issue;
  logic            accept;

  logic            o_valid_q, o_valid_d;
  logic [XLEN-1:0] o_res_q,   o_res_d;
  logic            o_cmp_q,   o_cmp_d;
  logic [1:0]      o_id_q,    o_id_d;
  logic [1:0]      ptr_q,     ptr_d;

  assign vld_vec   = {bus.qiu_i_valid, bus.lsu_i_valid, bus.bjp_i_valid, bus.alu_i_valid};
  assign can_issue = (~o_valid_q | bus.o_ready) & ~bus.flush;

  // Search starts at the pointer for round-robin, at ALU for fixed priority.
  always_comb begin
    logic [1:0] idx;
    gnt_found = 1'b0;
    gnt_id    = 2'd0;
    idx       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = RR_EN ? (ptr_q + 2'(i)) : 2'(i);
      if (!gnt_found && vld_vec[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  assign accept = gnt_found & can_issue;
  assign gnt_oh = accept ? (4'b0001 << gnt_id) : 4'b0000;

  assign bus.alu_req_alu = gnt_oh[0];
  assign bus.bjp_req_alu = gnt_oh[1];
  assign bus.lsu_req_alu = gnt_oh[2];
  assign bus.qiu_req_alu = gnt_oh[3];
  assign bus.alu_i_ready = gnt_oh[0];
  assign bus.bjp_i_ready = gnt_oh[1];
  assign bus.lsu_i_ready = gnt_oh[2];
  assign bus.qiu_i_ready = gnt_oh[3];

  // Flush dominates both drain and accept; data registers only move on accept.
  always_comb begin
    o_valid_d = o_valid_q;
    o_res_d   = o_res_q;
    o_cmp_d   = o_cmp_q;
    o_id_d    = o_id_q;
    ptr_d     = ptr_q;
    if (bus.flush) begin
      o_valid_d = 1'b0;
    end else if (accept) begin
      o_valid_d = 1'b1;
      o_res_d   = bus.dpath_res;
      o_cmp_d   = (gnt_id == ID_BJP) ? bus.dpath_cmp_res : 1'b0;
      o_id_d    = gnt_id;
      ptr_d     = gnt_id + 2'd1;
    end else if (bus.o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_q <= 1'b0;
      o_res_q   <= '0;
      o_cmp_q   <= 1'b0;
      o_id_q    <= 2'd0;
      ptr_q     <= 2'd0;
    end else begin
      o_valid_q <= o_valid_d;
      o_res_q   <= o_res_d;
      o_cmp_q   <= o_cmp_d;
      o_id_q    <= o_id_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_res   = o_res_q;
  assign bus.o_cmp   = o_cmp_q;
  assign bus.o_id    = o_id_q;

endmodule

// File: tb/tb_qpu_exu_alu_dpath_arb.sv
// Directed bench: a reference grant/response model feeds a scoreboard queue that is
// checked against both a round-robin and a fixed-priority instance of the arbiter.
module tb_qpu_exu_alu_dpath_arb;

  logic clk;
  logic rst_n;

  qpu_exu_alu_dpath_arb_if #(.XLEN(32)) bus_rr ();
  qpu_exu_alu_dpath_arb_if #(.XLEN(32)) bus_fp ();

  qpu_exu_alu_dpath_arb #(.XLEN(32), .RR_EN(1'b1)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_rr.slave)
  );

  qpu_exu_alu_dpath_arb #(.XLEN(32), .RR_EN(1'b0)) u_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        cmp;
    logic [1:0]  id;
  } exp_t;

  exp_t       sb[$];
  logic       m_valid;
  logic [1:0] m_ptr;
  int         n_tests;
  int         n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {found, id}: first valid at or after p (rr) or lowest index (fixed).
  function automatic logic [2:0] mgrant(input logic [3:0] v, input logic [1:0] p, input bit rr);
    logic [1:0] k;
    for (int i = 0; i < 4; i++) begin
      k = rr ? p + 2'(i) : 2'(i);
      if (v[k]) return {1'b1, k};
    end
    return 3'b000;
  endfunction

  task automatic drive_rr(input logic [3:0] v, input logic ordy, input logic fl,
                          input logic [31:0] res, input logic cmp);
    bus_rr.alu_i_valid   = v[0];
    bus_rr.bjp_i_valid   = v[1];
    bus_rr.lsu_i_valid   = v[2];
    bus_rr.qiu_i_valid   = v[3];
    bus_rr.o_ready       = ordy;
    bus_rr.flush         = fl;
    bus_rr.dpath_res     = res;
    bus_rr.dpath_cmp_res = cmp;
  endtask

  // One cycle on the round-robin instance: drive at negedge, check mid-cycle, advance model.
  task automatic step(input logic [3:0] v, input logic ordy, input logic fl,
                      input logic [31:0] res, input logic cmp);
    logic [2:0] g;
    logic       acc;
    logic [3:0] exp_oh;
    exp_t       e;
    drive_rr(v, ordy, fl, res, cmp);
    #1;
    g      = mgrant(v, m_ptr, 1'b1);
    acc    = g[2] && (!m_valid || ordy) && !fl;
    exp_oh = acc ? (4'b0001 << g[1:0]) : 4'b0000;
    chk("sel",  {28'd0, bus_rr.qiu_req_alu, bus_rr.lsu_req_alu, bus_rr.bjp_req_alu, bus_rr.alu_req_alu}, {28'd0, exp_oh});
    chk("rdy",  {28'd0, bus_rr.qiu_i_ready, bus_rr.lsu_i_ready, bus_rr.bjp_i_ready, bus_rr.alu_i_ready}, {28'd0, exp_oh});
    chk("o_valid", {31'd0, bus_rr.o_valid}, {31'd0, m_valid});
    if (m_valid && sb.size() > 0) begin
      chk("o_res", bus_rr.o_res, sb[0].res);
      chk("o_id",  {30'd0, bus_rr.o_id}, {30'd0, sb[0].id});
      chk("o_cmp", {31'd0, bus_rr.o_cmp}, {31'd0, sb[0].cmp});
    end
    if (fl) begin
      sb.delete();
      m_valid = 1'b0;
    end else begin
      if (m_valid && ordy && sb.size() > 0) void'(sb.pop_front());
      if (acc) begin
        e.res = res;
        e.cmp = (g[1:0] == 2'd1) ? cmp : 1'b0;
        e.id  = g[1:0];
        sb.push_back(e);
        m_ptr = g[1:0] + 2'd1;
      end
      m_valid = acc || (m_valid && !ordy);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_valid = 1'b0;
    m_ptr   = 2'd0;
    rst_n   = 1'b0;
    drive_rr(4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    bus_fp.alu_i_valid = 0; bus_fp.bjp_i_valid = 0; bus_fp.lsu_i_valid = 0; bus_fp.qiu_i_valid = 0;
    bus_fp.o_ready = 1'b1; bus_fp.flush = 1'b0; bus_fp.dpath_res = 32'h0; bus_fp.dpath_cmp_res = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_o_valid", {31'd0, bus_rr.o_valid}, 32'd0);
    chk("rst_o_res",   bus_rr.o_res, 32'd0);
    chk("rst_o_id",    {30'd0, bus_rr.o_id}, 32'd0);
    chk("rst_o_cmp",   {31'd0, bus_rr.o_cmp}, 32'd0);
    chk("rst_fp_valid", {31'd0, bus_fp.o_valid}, 32'd0);
    rst_n = 1'b1;

    // All four requesting: rotation 0,1,2,3,0
    for (int i = 0; i < 5; i++) step(4'hF, 1'b1, 1'b0, $urandom, 1'b1);
    step(4'h0, 1'b1, 1'b0, 32'h0, 1'b0);

    // Lone LSU; compare output must be forced low for non-BJP
    step(4'b0100, 1'b1, 1'b0, 32'h0000_1004, 1'b1);
    step(4'h0, 1'b1, 1'b0, 32'h0, 1'b0);

    // BJP compare, then 3 stalled cycles with ALU+BJP pending, then drain+accept
    step(4'b0010, 1'b0, 1'b0, 32'h0000_00AA, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0011, 1'b0, 1'b0, $urandom, 1'b0);
    step(4'b0011, 1'b1, 1'b0, 32'h1234_5678, 1'b0);
    step(4'b0010, 1'b1, 1'b0, 32'h0000_0055, 1'b1);
    step(4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(4'h0, 1'b1, 1'b0, 32'h0, 1'b0);

    // Flush with a pending response and a pending ALU request
    step(4'b0001, 1'b0, 1'b0, 32'hCAFE_0001, 1'b0);
    step(4'b0001, 1'b1, 1'b1, 32'hCAFE_0002, 1'b0);
    step(4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(4'hF, 1'b1, 1'b0, 32'hCAFE_0003, 1'b1);
    step(4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(4'h0, 1'b1, 1'b0, 32'h0, 1'b0);

    // Fixed priority: ALU always beats QIU
    for (int i = 0; i < 5; i++) begin
      bus_fp.alu_i_valid = 1'b1;
      bus_fp.qiu_i_valid = 1'b1;
      bus_fp.dpath_res   = 32'h100 + 32'(i);
      #1;
      chk("fp_alu_sel",   {31'd0, bus_fp.alu_req_alu}, 32'd1);
      chk("fp_qiu_ready", {31'd0, bus_fp.qiu_i_ready}, 32'd0);
      chk("fp_qiu_sel",   {31'd0, bus_fp.qiu_req_alu}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("fp_o_id",  {30'd0, bus_fp.o_id}, 32'd0);
      chk("fp_o_res", bus_fp.o_res, 32'h100 + 32'(i));
    end
    bus_fp.alu_i_valid = 1'b0;
    bus_fp.qiu_i_valid = 1'b0;

    // Reset during a stall, then ALU must win from the reset pointer
    step(4'b0100, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    step(4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_o_valid", {31'd0, bus_rr.o_valid}, 32'd0);
    chk("async_o_res",   bus_rr.o_res, 32'd0);
    chk("async_o_id",    {30'd0, bus_rr.o_id}, 32'd0);
    sb.delete();
    m_valid = 1'b0;
    m_ptr   = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'hF, 1'b1, 1'b0, 32'h0000_0777, 1'b0);
    step(4'h0, 1'b1, 1'b0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
